// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined parallel-prefix adder.
//   pg_t         : propagate/generate pair handled by one prefix cell
//   calc_levels  : number of prefix levels for a given operand width
//   calc_nstg    : cycles from accept to o_valid for a width / register spacing
package adder_pkg;

  typedef struct packed {
    logic p;
    logic g;
  } pg_t;

  function automatic int calc_levels(input int width);
    return $clog2(width);
  endfunction

  // One cycle for the pg register, then one per group of reg_every levels.
  // The last group's register is the output register holding sum and flags.
  function automatic int calc_nstg(input int width, input int reg_every);
    int lv;
    lv = $clog2(width);
    return 1 + (lv + reg_every - 1) / reg_every;
  endfunction

endpackage

// File: rtl/prefix_adder_pipe_cell.sv
// prefix_cell: generalised carry-combine cell of the prefix tree.
// Merges the group (p_i, g_i) with the lower group (p_j, g_j).
// Ports:
//   p_i, g_i   : propagate/generate of the upper (more significant) group
//   p_j, g_j   : propagate/generate of the lower group
//   p_out      : combined propagate
//   g_out      : combined generate
module prefix_cell
  import adder_pkg::*;
(
  input  logic p_i,
  input  logic g_i,
  input  logic p_j,
  input  logic g_j,
  output logic p_out,
  output logic g_out
);

  pg_t hi;
  pg_t lo;
  pg_t res;

  assign hi    = '{p: p_i, g: g_i};
  assign lo    = '{p: p_j, g: g_j};

  assign res.g = hi.g | (hi.p & lo.g);
  assign res.p = hi.p & lo.p;

  assign p_out = res.p;
  assign g_out = res.g;

endmodule

// File: rtl/prefix_adder_pipe.sv
// prefix_adder_pipe: pipelined Kogge-Stone adder/subtractor with
// valid/ready handshake, synchronous flush and status flags.
// Parameters:
//   WIDTH      : operand/sum width, power of two (8..64)
//   REG_EVERY  : a pipeline register follows every REG_EVERY prefix levels
// Ports:
//   i_clk, i_rst_n   : clock (rising edge), async active-low reset
//   i_flush          : kills every in-flight operation, drops this cycle's input
//   i_valid, o_ready : input handshake
//   i_a, i_b         : operands
//   i_cin            : carry-in (ignored when subtracting)
//   i_sub            : 1 selects A - B
//   o_valid, i_ready : output handshake
//   o_sum            : result
//   o_cout           : carry out of the MSB (1 = no borrow when subtracting)
//   o_ovf            : signed overflow
//   o_zero           : o_sum == 0
//
// Internally the carry chain has WIDTH+1 positions: position 0 holds the
// effective carry-in as a generate-only term, position i+1 holds bit i.
module prefix_adder_pipe
  import adder_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int REG_EVERY = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf,
  output logic             o_zero
);

  localparam int LEVELS = calc_levels(WIDTH);
  localparam int NSTG   = calc_nstg(WIDTH, REG_EVERY);
  // Registers ahead of the output register: index 0 is the pg register,
  // the rest sit inside the prefix tree.
  localparam int NTREG  = NSTG - 1;

  logic             stall;
  logic             accept;
  logic [NSTG-1:0]  vld;

  logic [WIDTH-1:0] b_eff;
  logic             c0;
  logic [WIDTH:0]   p_in;
  logic [WIDTH:0]   g_in;

  logic [WIDTH:0]   st_p  [NTREG];
  logic [WIDTH:0]   st_g  [NTREG];
  logic [WIDTH-1:0] st_po [NTREG];

  logic [WIDTH:0]   src_p [LEVELS];
  logic [WIDTH:0]   src_g [LEVELS];
  logic [WIDTH:0]   res_p [LEVELS];
  logic [WIDTH:0]   res_g [LEVELS];

  logic [WIDTH:0]   fin_p;
  logic [WIDTH:0]   fin_g;
  logic [WIDTH-1:0] fin_po;
  logic [WIDTH-1:0] sum_c;
  logic             cout_c;
  logic             ovf_c;
  logic             unused_fin_p;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  assign stall   = vld[NSTG-1] & ~i_ready;
  assign o_ready = ~stall & ~i_flush;
  assign accept  = i_valid & o_ready;
  assign o_valid = vld[NSTG-1];

  // ---------------------------------------------------------------------------
  // Per-bit propagate/generate with the carry-in folded in at position 0
  // ---------------------------------------------------------------------------
  assign b_eff = i_sub ? ~i_b : i_b;
  assign c0    = i_sub | i_cin;
  assign p_in  = {i_a ^ b_eff, 1'b0};
  assign g_in  = {i_a & b_eff, c0};

  // ---------------------------------------------------------------------------
  // Prefix tree. Level k combines span 2^k; positions below the span pass
  // through. A level whose index is a multiple of REG_EVERY starts from a
  // stage register, otherwise it chains directly off the previous level.
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int SPAN = 1 << k;

    if (k % REG_EVERY == 0) begin : g_from_reg
      assign src_p[k] = st_p[k / REG_EVERY];
      assign src_g[k] = st_g[k / REG_EVERY];
    end else begin : g_from_comb
      assign src_p[k] = res_p[k-1];
      assign src_g[k] = res_g[k-1];
    end

    for (genvar i = 0; i <= WIDTH; i++) begin : g_bit
      if (i >= SPAN) begin : g_cell
        prefix_cell u_cell (
          .p_i   (src_p[k][i]),
          .g_i   (src_g[k][i]),
          .p_j   (src_p[k][i-SPAN]),
          .g_j   (src_g[k][i-SPAN]),
          .p_out (res_p[k][i]),
          .g_out (res_g[k][i])
        );
      end else begin : g_pass
        assign res_p[k][i] = src_p[k][i];
        assign res_g[k][i] = src_g[k][i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Final combine: fin_g[i] is the carry into bit i for i < WIDTH. The tree
  // spans exactly WIDTH positions, so the top position covers bits 0..WIDTH-1
  // without the carry-in; the carry-in (fin_g[0]) is merged in one more step.
  // ---------------------------------------------------------------------------
  assign fin_p  = res_p[LEVELS-1];
  assign fin_g  = res_g[LEVELS-1];
  assign fin_po = st_po[NTREG-1];

  assign sum_c  = fin_po ^ fin_g[WIDTH-1:0];
  assign cout_c = fin_g[WIDTH] | (fin_p[WIDTH] & fin_g[0]);
  assign ovf_c  = fin_g[WIDTH-1] ^ cout_c;

  // Group propagates of the lower positions are not needed after the last level.
  assign unused_fin_p = ^fin_p[WIDTH-1:0];

  // ---------------------------------------------------------------------------
  // Stage registers. Flush wins over stall; under stall everything holds.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld    <= '0;
      o_sum  <= '0;
      o_cout <= 1'b0;
      o_ovf  <= 1'b0;
      o_zero <= 1'b0;
      for (int s = 0; s < NTREG; s++) begin
        st_p[s]  <= '0;
        st_g[s]  <= '0;
        st_po[s] <= '0;
      end
    end else if (i_flush) begin
      vld <= '0;
    end else if (!stall) begin
      vld      <= {vld[NSTG-2:0], accept};
      st_p[0]  <= p_in;
      st_g[0]  <= g_in;
      st_po[0] <= i_a ^ b_eff;
      for (int s = 1; s < NTREG; s++) begin
        st_p[s]  <= res_p[s*REG_EVERY-1];
        st_g[s]  <= res_g[s*REG_EVERY-1];
        st_po[s] <= st_po[s-1];
      end
      // Only real operations update the visible result; bubbles leave it alone.
      if (vld[NSTG-2]) begin
        o_sum  <= sum_c;
        o_cout <= cout_c;
        o_ovf  <= ovf_c;
        o_zero <= (sum_c == '0);
      end
    end
  end

endmodule

// File: tb/tb_prefix_adder_pipe.sv
module tb_prefix_adder_pipe;

  localparam int W = 32;

  logic         i_clk   = 1'b0;
  logic         i_rst_n = 1'b0;
  logic         i_flush = 1'b0;
  logic         i_valid = 1'b0;
  logic         i_ready = 1'b1;
  logic         i_cin   = 1'b0;
  logic         i_sub   = 1'b0;
  logic [W-1:0] i_a     = '0;
  logic [W-1:0] i_b     = '0;
  logic         o_ready;
  logic         o_valid;
  logic [W-1:0] o_sum;
  logic         o_cout;
  logic         o_ovf;
  logic         o_zero;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
  } exp_t;

  exp_t sb_q[$];
  int   total  = 0;
  int   passed = 0;

  always #5 i_clk = ~i_clk;

  prefix_adder_pipe #(.WIDTH(W), .REG_EVERY(2)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_flush (i_flush),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_a     (i_a),
    .i_b     (i_b),
    .i_cin   (i_cin),
    .i_sub   (i_sub),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_sum   (o_sum),
    .o_cout  (o_cout),
    .o_ovf   (o_ovf),
    .o_zero  (o_zero)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
  endtask

  // Reference: plain wide addition, overflow from operand/result signs.
  function automatic exp_t model(input logic [W-1:0] a, b, input logic cin, sub);
    exp_t         m;
    logic [W-1:0] bb;
    logic         c;
    bb = sub ? ~b : b;
    c  = sub | cin;
    {m.cout, m.sum} = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c};
    m.ovf  = (a[W-1] == bb[W-1]) && (m.sum[W-1] != a[W-1]);
    m.zero = (m.sum == '0);
    return m;
  endfunction

  // Scoreboard monitor: every consumed result is popped and compared.
  always @(negedge i_clk) begin
    if (i_rst_n && o_valid && i_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_result", {63'b0, o_valid}, 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("result", {29'b0, o_sum, o_cout, o_ovf, o_zero}, {29'b0, e});
      end
    end
  end

  // One cycle: drive after the edge, sample acceptance at the falling edge.
  task automatic cyc_drive(input logic v, input logic [W-1:0] a, b,
                           input logic cin, sub, flush, rdy,
                           input exp_t e, output logic acc);
    @(posedge i_clk);
    #1;
    i_valid = v;
    i_a     = a;
    i_b     = b;
    i_cin   = cin;
    i_sub   = sub;
    i_flush = flush;
    i_ready = rdy;
    @(negedge i_clk);
    acc = v && o_ready;
    if (acc) sb_q.push_back(e);
  endtask

  task automatic idle(input int n);
    logic unused_acc;
    for (int k = 0; k < n; k++) cyc_drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, '0, unused_acc);
  endtask

  task automatic dvec(input logic [W-1:0] a, b, input logic cin, sub,
                      input logic [W-1:0] s, input logic co, ov, z);
    exp_t e;
    logic acc;
    e.sum  = s;
    e.cout = co;
    e.ovf  = ov;
    e.zero = z;
    cyc_drive(1'b1, a, b, cin, sub, 1'b0, 1'b1, e, acc);
    chk("directed_accept", {63'b0, acc}, 64'd1);
  endtask

  task automatic measure_latency(input string name);
    int   lat;
    logic unused_acc;
    lat = 0;
    while (!o_valid && lat < 20) begin
      cyc_drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, '0, unused_acc);
      lat++;
    end
    chk(name, 64'(lat), 64'd4);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] ra [10];
    logic [W-1:0] rb [10];
    logic         rc [10];
    logic         rs [10];
    logic [W+2:0] snap;
    logic         acc;
    int           idx;

    // Reset state
    repeat (2) @(posedge i_clk);
    #1;
    chk("reset_valid", {63'b0, o_valid}, 64'd0);
    chk("reset_sum",   {32'b0, o_sum},   64'd0);
    chk("reset_flags", {61'b0, o_cout, o_ovf, o_zero}, 64'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // Add wrap plus first-result latency
    dvec(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    measure_latency("latency_first");
    idle(2);

    // Directed vectors back to back
    dvec(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    dvec(32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    dvec(32'h5, 32'h3, 1'b1, 1'b0, 32'h9, 1'b0, 1'b0, 1'b0);
    dvec(32'h5, 32'h3, 1'b0, 1'b1, 32'h2, 1'b1, 1'b0, 1'b0);
    dvec(32'h3, 32'h5, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    dvec(32'h5, 32'h3, 1'b1, 1'b1, 32'h2, 1'b1, 1'b0, 1'b0);
    dvec(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    dvec(32'h5, 32'h5, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1);
    dvec(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    idle(8);
    chk("directed_drained", 64'(sb_q.size()), 64'd0);

    // Backpressure: 10 random ops, i_ready low for cycles 5..8
    for (int k = 0; k < 10; k++) begin
      ra[k] = $urandom();
      rb[k] = $urandom();
      rc[k] = 1'($urandom_range(0, 1));
      rs[k] = 1'($urandom_range(0, 1));
    end
    idx  = 0;
    snap = '0;
    for (int c = 0; c < 14; c++) begin
      logic rdy;
      logic v;
      rdy = !(c >= 5 && c <= 8);
      v   = (idx < 10);
      if (v) cyc_drive(1'b1, ra[idx], rb[idx], rc[idx], rs[idx], 1'b0, rdy,
                       model(ra[idx], rb[idx], rc[idx], rs[idx]), acc);
      else   cyc_drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, rdy, '0, acc);
      chk($sformatf("bp_ready_c%0d", c), {63'b0, o_ready}, {63'b0, rdy});
      if (acc) idx++;
      if (c == 5) snap = {o_sum, o_cout, o_ovf, o_zero};
      if (c >= 6 && c <= 8) begin
        chk("stall_stable", {29'b0, o_sum, o_cout, o_ovf, o_zero}, {29'b0, snap});
        chk("stall_valid", {63'b0, o_valid}, 64'd1);
      end
    end
    chk("bp_all_accepted", 64'(idx), 64'd10);
    idle(10);
    chk("bp_drained", 64'(sb_q.size()), 64'd0);

    // Flush with three ops in flight and a fourth presented in the flush cycle
    for (int k = 0; k < 3; k++)
      cyc_drive(1'b1, ra[k], rb[k], rc[k], rs[k], 1'b0, 1'b1,
                model(ra[k], rb[k], rc[k], rs[k]), acc);
    cyc_drive(1'b1, ra[3], rb[3], rc[3], rs[3], 1'b1, 1'b1,
              model(ra[3], rb[3], rc[3], rs[3]), acc);
    chk("flush_ready", {63'b0, o_ready}, 64'd0);
    sb_q.delete();
    idle(1);
    chk("flush_valid_next", {63'b0, o_valid}, 64'd0);
    dvec(32'h0000_1234, 32'h0000_0010, 1'b0, 1'b1, 32'h0000_1224, 1'b1, 1'b0, 1'b0);
    measure_latency("flush_then_latency");
    idle(6);
    chk("flush_drained", 64'(sb_q.size()), 64'd0);

    // Asynchronous reset in the middle of a stream
    for (int k = 4; k < 10; k++)
      cyc_drive(1'b1, ra[k], rb[k], rc[k], rs[k], 1'b0, 1'b1,
                model(ra[k], rb[k], rc[k], rs[k]), acc);
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    chk("pre_reset_valid", {63'b0, o_valid}, 64'd1);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("async_reset_valid", {63'b0, o_valid}, 64'd0);
    chk("async_reset_sum",   {32'b0, o_sum},   64'd0);
    sb_q.delete();
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    #2;
    i_rst_n = 1'b1;
    idle(10);
    chk("post_reset_valid", {63'b0, o_valid}, 64'd0);
    chk("final_drained", 64'(sb_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/prefix_adder_pipe.md
Name: prefix_adder_pipe

Overview:
- Parametrised, pipelined Kogge-Stone parallel-prefix adder/subtractor.
- Next generation of the single-bit pg / carry-combine / sum cells. Generalises them to WIDTH bits, with configurable pipeline register placement, add/sub mode, carry-in, status flags and a valid/ready handshake.
- Sits between the ALU operand mux and the writeback/flag logic of the pipelined datapath.

Parameters:
- WIDTH, 32, operand/sum width in bits, power of two, 8..64.
- REG_EVERY, 2, insert a pipeline register after every REG_EVERY prefix levels, 1..LEVELS. LEVELS = clog2(WIDTH).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_flush  in  1  synchronous flush; kills all in-flight operations.
- i_valid  in  1  input operation valid.
- o_ready  out  1  adder can accept an operation this cycle.
- i_a  in  WIDTH  operand A.
- i_b  in  WIDTH  operand B.
- i_cin  in  1  carry-in; used only when i_sub=0.
- i_sub  in  1  1 = A - B (B inverted, carry-in forced 1).
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts the result.
- o_sum  out  WIDTH  result.
- o_cout  out  1  carry-out of MSB (for subtraction: 1 = no borrow).
- o_ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.
- o_zero  out  1  o_sum == 0.

Behaviour:
- Reset: asynchronous, active-low; all stage valid bits and all outputs (o_valid, o_sum, o_cout, o_ovf, o_zero) clear to 0 immediately. Operation resumes on the first rising edge after i_rst_n deasserts.
- Stage structure:
  - Stage 0 registers the per-bit p = a^b' and g = a&b', where b' = i_sub ? ~i_b : i_b, plus the effective carry-in c0 = i_sub | i_cin. c0 is folded in as bit -1 generate.
  - Prefix levels k = 0..LEVELS-1 combine span 2^k: g_out = g_i | (p_i & g_{i-2^k}), p_out = p_i & p_{i-2^k}.
  - A register follows every REG_EVERY levels, and after the final level.
  - Final stage: sum_i = p_i ^ G_{i-1}; flags are computed and registered.
- Latency: NSTG = 1 + ceil(LEVELS/REG_EVERY) cycles from accept to o_valid. For WIDTH=32, REG_EVERY=2, latency is 4.
- Throughput: one operation per cycle when unstalled.
- Handshake:
  - An input is accepted when i_valid && o_ready.
  - A result is consumed when o_valid && i_ready.
  - stall = o_valid && !i_ready. When stalled, every stage register holds its value.
  - o_ready = !stall && !i_flush.
  - Output data and flags stay stable while o_valid=1 and i_ready=0.
- Bubbles are not collapsed. Stage valid bits simply shift when not stalled.
- Flush:
  - On an i_flush edge, all stage valid bits clear, including the output stage, so o_valid=0 next cycle.
  - Any input presented that cycle is dropped (o_ready is 0).
  - Flush has priority over stall.
  - Data registers need not clear.
- Ordering: results emerge strictly in input order. No operation is lost or duplicated under any i_ready pattern.
- Width rules:
  - Carries are WIDTH+1 bits internally; o_cout is the bit-WIDTH carry.
  - o_ovf is defined for both add and sub using the effective b'.
- Reset mid-operation: all in-flight operations are discarded and nothing is emitted afterwards.

Decomposition:
- Shared package adder_pkg holds:
  - function clog2-based LEVELS(width);
  - function NSTG(width, reg_every);
  - typedef pg_t (packed struct {p, g}).
- One natural sub-module: prefix_cell, the generalised carry-combine cell (inputs p_i, g_i, p_j, g_j; outputs p_out, g_out). It is instantiated per bit per level, with pass-through for bits i < 2^k.
- Stage registers are generated in the top level.

Test Plan (WIDTH=32, REG_EVERY=2, latency 4):
- Add wrap: a=0xFFFFFFFF, b=1, cin=0, sub=0 -> after 4 cycles o_sum=0, cout=1, zero=1, ovf=0.
- Signed overflow: a=0x7FFFFFFF, b=1 -> o_sum=0x80000000, ovf=1, cout=0. Subtract: a=0x80000000, b=1, sub=1 -> o_sum=0x7FFFFFFF, ovf=1, cout=1.
- Carry-in/sub precedence: a=5, b=3, cin=1, sub=0 -> 9. Same operands with sub=1, cin=0 -> 2, cout=1. a=3, b=5, sub=1 -> 0xFFFFFFFE, cout=0.
- Backpressure: 10 back-to-back random operations, i_ready low for cycles 5-8 -> o_ready low exactly while stalled, all 10 results in order matching a reference model, outputs stable during the stall.
- Flush: 3 operations in flight, i_flush pulsed with i_valid=1 -> o_ready=0 that cycle, o_valid=0 from the next cycle, none of the 4 operations emitted, an operation issued afterwards appears 4 cycles later.
- Async reset: i_rst_n low mid-stream between clock edges -> o_valid and o_sum go to 0 without a clock edge, and nothing from earlier operations appears after release.
